ins_encoder: RTL and testbench

INS_ENCODER -- requirements
Module: ins_encoder

---
 rtl/isa_pkg.sv | 31 +++
 rtl/ins_pack.sv | 46 ++++
 rtl/ins_encoder.sv | 98 +++++++++
 tb/tb_ins_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: format codes, encoder FSM states, field widths and bit offsets.
// Decode-side logic imports the same constants so both ends agree on the instruction layout.
package isa_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORD_W  = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int AUX_W   = 11;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  // A 32-bit immediate fits in 16 bits if its upper half is zero or a sign extension.
  function automatic logic imm_fits(input logic [31:0] v);
    return (v[31:16] == 16'h0000) || (v[31:16] == {16{v[15]}});
  endfunction

endpackage

// File: rtl/ins_pack.sv
// Combinational packing of R/I/J instruction fields into a 32-bit word; zero latency.
// Flags illegal formats and I-type immediates that do not fit in 16 bits; no backpressure.
module ins_pack
  import isa_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [AUX_W-1:0]   aux,
  input  logic [31:0]        imm_dpl,
  input  logic [JADDR_W-1:0] addr,
  output logic [WORD_W-1:0]  word,
  output logic               legal,
  output logic               imm_err
);

  always_comb begin
    word    = '0;
    legal   = 1'b1;
    imm_err = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OP_LSB +: OP_W]  = op;
        word[RS_LSB +: REG_W] = rs;
        word[RT_LSB +: REG_W] = rt;
        word[RD_LSB +: REG_W] = rd;
        word[0 +: AUX_W]      = aux;
      end
      FMT_I: begin
        word[OP_LSB +: OP_W]  = op;
        word[RS_LSB +: REG_W] = rs;
        word[RT_LSB +: REG_W] = rt;
        word[0 +: IMM_W]      = imm_dpl[IMM_W-1:0];
        imm_err               = !imm_fits(imm_dpl);
      end
      FMT_J: begin
        word[OP_LSB +: OP_W]  = op;
        word[0 +: JADDR_W]    = addr;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// Encodes field sets into instruction memory words; accepted set appears on mem_wdata one cycle later.
// in_ready drops while a write is stalled by mem_ready, and stays low once memory is full until start.
module ins_encoder
  import isa_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         fmt,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [AUX_W-1:0]   aux,
  input  logic [31:0]        imm_dpl,
  input  logic [JADDR_W-1:0] addr,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [AW-1:0]      mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic [AW:0]        count,
  output logic               full,
  output logic               err
);

  logic [1:0]        state;
  logic [WORD_W-1:0] pack_word;
  logic              pack_legal;
  logic              pack_imm_err;
  logic              accept;
  logic              write_done;
  logic              last_write;

  ins_pack u_pack (
    .fmt     (fmt),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .aux     (aux),
    .imm_dpl (imm_dpl),
    .addr    (addr),
    .word    (pack_word),
    .legal   (pack_legal),
    .imm_err (pack_imm_err)
  );

  assign in_ready   = (state == ST_RUN) && !start && (!mem_we || mem_ready);
  assign accept     = in_valid && in_ready;
  assign write_done = mem_we && mem_ready;
  assign last_write = write_done && (&mem_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      state    <= ST_RUN;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      count    <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (write_done) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + AW'(1);
        count    <= count + (AW+1)'(1);
      end
      if (last_write) begin
        state <= ST_DONE;
        full  <= 1'b1;
      end
      if (accept) begin
        if (!pack_legal) begin
          err <= 1'b1;
        end else if (last_write) begin
          // Memory just filled: this set has nowhere to go, so flag it rather than wrap.
          err <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_wdata <= pack_word;
          if (pack_imm_err) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// Scoreboard bench for ins_encoder (AW=2): directed field sets push expected writes, a monitor checks them.
module tb_ins_encoder;

  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [10:0] aux = '0;
  logic [31:0] imm_dpl = '0;
  logic [25:0] jaddr = '0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [AW:0] count;
  logic        full;
  logic        err;

  ins_encoder #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .aux(aux), .imm_dpl(imm_dpl),
    .addr(jaddr), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed write must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mem_we && mem_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (mem_addr !== e.a || mem_wdata !== e.d) begin
            n_fail++;
            $display("FAIL write: got addr 0x%0h data 0x%08h expected addr 0x%0h data 0x%08h",
                     mem_addr, mem_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [10:0] x,
                      input logic [31:0] imm, input logic [25:0] ja,
                      input logic [31:0] exp_word, input bit exp_write);
    int k;
    @(negedge clk);
    fmt = f; op = o; rs = s; rt = t; rd = d; aux = x; imm_dpl = imm; jaddr = ja;
    in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
    end
    if (exp_write) begin
      sb.push_back('{a: exp_addr, d: exp_word});
      exp_addr = exp_addr + 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_mem_we", mem_we, exp_write);
    if (exp_write) check("latency_wdata", mem_wdata, exp_word);
  endtask

  initial begin
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_count", count, 0);
    check("rst_outputs", {mem_addr, mem_wdata, full, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Session 1: R and I encodings, immediate range error.
    do_start();
    #1;
    check("start_in_ready", in_ready, 1);
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 11'h020, 32'h0, 26'h0, 32'h00221820, 1'b1);
    check("r_mem_addr", mem_addr, 0);
    check("r_err", err, 0);
    send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 11'h0, 32'hFFFF_FFFF, 26'h0, 32'h2022FFFF, 1'b1);
    check("i_sext_err", err, 0);
    send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 11'h0, 32'h0001_0000, 26'h0, 32'h20220000, 1'b1);
    check("i_range_err", err, 1);
    @(negedge clk);
    check("s1_count", count, 3);

    // Session 2: J, illegal format, stall, fill to full.
    do_start();
    check("restart_err", err, 0);
    check("restart_count", count, 0);
    send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 11'h0, 32'h0, 26'h0000010, 32'h08000010, 1'b1);
    send(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 11'h1, 32'h0, 26'h0, 32'h0, 1'b0);
    check("bad_err", err, 1);
    check("bad_count", count, 1);
    check("bad_mem_addr", mem_addr, 1);

    mem_ready = 1'b0;
    send(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 11'h0, 32'h0, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_mem_we", mem_we, 1);
      check("stall_mem_addr", mem_addr, 1);
      check("stall_wdata", mem_wdata, 32'h0FFFFFFF);
      check("stall_in_ready", in_ready, 0);
      check("stall_count", count, 1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("release_count", count, 2);

    send(2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 11'h7FF, 32'h0, 26'h0, 32'hFFFFFFFF, 1'b1);
    send(2'd1, 6'h0F, 5'd0, 5'd0, 5'd0, 11'h0, 32'h0000_8000, 26'h0, 32'h3C008000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("full_flag", full, 1);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    check("full_mem_addr", mem_addr, 0);
    in_valid = 1'b0;

    do_start();
    #1;
    check("after_full_addr", mem_addr, 0);
    check("after_full_count", count, 0);
    check("after_full_full", full, 0);
    check("after_full_in_ready", in_ready, 1);

    // Reset during a stalled write.
    mem_ready = 1'b0;
    send(2'd0, 6'd1, 5'd0, 5'd0, 5'd0, 11'h0, 32'h0, 26'h0, 32'h04000000, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_outputs", {mem_addr, mem_wdata, count, full, err}, 0);
    check("mid_rst_in_ready", in_ready, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_no_write", mem_we, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
